neuron_tdm_sched: RTL and testbench

- Time-multiplexed scheduler that shares one integrate-and-fire update datapath across NUM_NEURONS neurons.
- On each timestep tick it walks neurons 0..NUM_NEURONS-1. For each neuron it requests that neuron's excitatory and inhibitory sums from the synapse accumulator, then applies decay, clamp, threshold and refractory rules, and writes the result back to internal per-neuron state.
- Each spike is emitted as an address-event on a valid/ready output.
- Sits between the synapse accumulator and the spike router.

---
 rtl/neuron_pkg.sv | 18 +
 rtl/neuron_tdm_sched_if.sv | 40 ++++
 rtl/neuron_update.sv | 42 ++++
 rtl/neuron_tdm_sched.sv | 135 +++++++++++++
 tb/tb_neuron_tdm_sched.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/neuron_pkg.sv
// Shared types and constants for the time-multiplexed integrate-and-fire scheduler.
package neuron_pkg;

  localparam int unsigned VOLT_W = 14;

  typedef logic [VOLT_W-1:0] volt_t;

  localparam volt_t THRESHOLD_DEFAULT = 14'h1300;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    UPD,
    EMIT,
    DONE
  } sched_state_t;

endpackage

// File: rtl/neuron_tdm_sched_if.sv
// Request/sums handshake toward the synapse accumulator and spike event stream
// toward the router. Signal names are from the scheduler's point of view.
interface neuron_tdm_sched_if
  import neuron_pkg::*;
#(
  parameter int unsigned IDX_W = 3
);

  logic             o_req_valid;
  logic [IDX_W-1:0] o_req_idx;
  logic             i_syn_valid;
  volt_t            i_sum_excit;
  volt_t            i_sum_inhibit;
  logic             o_evt_valid;
  logic [IDX_W-1:0] o_evt_idx;
  logic             i_evt_ready;

  modport master (
    output o_req_valid,
    output o_req_idx,
    input  i_syn_valid,
    input  i_sum_excit,
    input  i_sum_inhibit,
    output o_evt_valid,
    output o_evt_idx,
    input  i_evt_ready
  );

  modport slave (
    input  o_req_valid,
    input  o_req_idx,
    output i_syn_valid,
    output i_sum_excit,
    output i_sum_inhibit,
    input  o_evt_valid,
    input  o_evt_idx,
    output i_evt_ready
  );

endinterface

// File: rtl/neuron_update.sv
// Combinational single-neuron update: leak, integrate, clamp, threshold, refractory.
module neuron_update
  import neuron_pkg::*;
#(
  parameter volt_t       THRESHOLD   = THRESHOLD_DEFAULT,
  parameter int unsigned DECAY_SHIFT = 3,
  parameter int unsigned REFRAC      = 2
) (
  input  volt_t       v,
  input  logic [3:0]  r,
  input  volt_t       excit,
  input  volt_t       inhibit,
  output volt_t       v_new,
  output logic        fire,
  output logic [3:0]  r_next
);

  logic [VOLT_W:0] decay;
  logic [VOLT_W:0] p;
  logic [VOLT_W:0] d;

  always_comb begin
    decay = {1'b0, v} - ({1'b0, v} >> DECAY_SHIFT);
    p     = {1'b0, excit} + decay;
    d     = '0;
    v_new = '0;
    // A refractory neuron is forced to zero regardless of input.
    if (r == 4'd0 && p > {1'b0, inhibit}) begin
      d     = p - {1'b0, inhibit};
      v_new = (d > 15'h3FFF) ? 14'h3FFF : d[VOLT_W-1:0];
    end
    fire = (r == 4'd0) && (v_new >= THRESHOLD);
    if (fire) begin
      r_next = 4'(REFRAC);
    end else if (r != 4'd0) begin
      r_next = r - 4'd1;
    end else begin
      r_next = 4'd0;
    end
  end

endmodule

// File: rtl/neuron_tdm_sched.sv
// Sweeps all neurons once per tick through one shared update datapath, fetching sums
// from the synapse accumulator and emitting spikes as address-events.
module neuron_tdm_sched
  import neuron_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 8,
  parameter int unsigned IDX_W       = $clog2(NUM_NEURONS),
  parameter volt_t       THRESHOLD   = THRESHOLD_DEFAULT,
  parameter int unsigned DECAY_SHIFT = 3,
  parameter int unsigned REFRAC      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_tick,
  neuron_tdm_sched_if.master        bus,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_overrun
);

  sched_state_t     state_q;
  logic [IDX_W-1:0] idx_q;
  logic             req_valid_q;
  logic             evt_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             overrun_q;
  volt_t            excit_q;
  volt_t            inhibit_q;
  volt_t            v_q [NUM_NEURONS];
  logic [3:0]       r_q [NUM_NEURONS];

  volt_t            upd_v;
  logic             upd_fire;
  logic [3:0]       upd_r;
  logic             last;

  assign last = (idx_q == IDX_W'(NUM_NEURONS - 1));

  neuron_update #(
    .THRESHOLD   (THRESHOLD),
    .DECAY_SHIFT (DECAY_SHIFT),
    .REFRAC      (REFRAC)
  ) u_update (
    .v       (v_q[idx_q]),
    .r       (r_q[idx_q]),
    .excit   (excit_q),
    .inhibit (inhibit_q),
    .v_new   (upd_v),
    .fire    (upd_fire),
    .r_next  (upd_r)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      req_valid_q <= 1'b0;
      evt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      excit_q     <= '0;
      inhibit_q   <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else begin
      overrun_q <= i_tick && (state_q != IDLE);
      done_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_tick) begin
            state_q     <= REQ;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            req_valid_q <= 1'b1;
          end
        end
        REQ: begin
          if (bus.i_syn_valid) begin
            excit_q     <= bus.i_sum_excit;
            inhibit_q   <= bus.i_sum_inhibit;
            req_valid_q <= 1'b0;
            state_q     <= UPD;
          end
        end
        UPD: begin
          v_q[idx_q] <= upd_fire ? '0 : upd_v;
          r_q[idx_q] <= upd_r;
          if (upd_fire) begin
            state_q     <= EMIT;
            evt_valid_q <= 1'b1;
          end else if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q       <= idx_q + 1'b1;
            state_q     <= REQ;
            req_valid_q <= 1'b1;
          end
        end
        EMIT: begin
          // Sweep stalls here until the router takes the event.
          if (bus.i_evt_ready) begin
            evt_valid_q <= 1'b0;
            if (last) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q       <= idx_q + 1'b1;
              state_q     <= REQ;
              req_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_req_valid = req_valid_q;
  assign bus.o_req_idx   = idx_q;
  assign bus.o_evt_valid = evt_valid_q;
  assign bus.o_evt_idx   = idx_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_overrun       = overrun_q;

endmodule

// File: tb/tb_neuron_tdm_sched.sv
// Directed bench for neuron_tdm_sched: table of per-tick sweeps plus a mid-sweep reset.
module tb_neuron_tdm_sched;
  import neuron_pkg::*;

  localparam int NN = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic i_tick = 1'b0;
  logic o_busy, o_done, o_overrun;

  neuron_tdm_sched_if #(.IDX_W(3)) bus ();

  neuron_tdm_sched #(.NUM_NEURONS(NN)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_tick    (i_tick),
    .bus       (bus),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_overrun (o_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    string                 name;
    logic [NN-1:0][13:0]   ex;
    logic [NN-1:0][13:0]   inh;
    int                    syn_delay;
    int                    stall;
    bit                    extra_tick;
    logic [NN-1:0]         exp_mask;
    int                    exp_cnt;
    int                    exp_done_cyc;
    int                    exp_ovr;
    logic [NN-1:0][13:0]   exp_v;
    logic [NN-1:0][3:0]    exp_r;
  } vec_t;

  vec_t vecs [7];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NN*14-1:0] snap_v();
    logic [NN-1:0][13:0] s;
    for (int i = 0; i < NN; i++) s[i] = dut.v_q[i];
    return s;
  endfunction

  function automatic logic [NN*4-1:0] snap_r();
    logic [NN-1:0][3:0] s;
    for (int i = 0; i < NN; i++) s[i] = dut.r_q[i];
    return s;
  endfunction

  function automatic vec_t blank(input string n);
    vec_t t;
    t.name = n;
    t.ex = '0;
    t.inh = '0;
    t.syn_delay = 0;
    t.stall = 0;
    t.extra_tick = 1'b0;
    t.exp_mask = '0;
    t.exp_cnt = 0;
    t.exp_done_cyc = 17;
    t.exp_ovr = 0;
    t.exp_v = '0;
    t.exp_r = '0;
    return t;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_vec(input vec_t t);
    int cyc = 0;
    int delay_cnt = 0;
    int stall_cnt = 0;
    int evt_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int ovr = 0;
    int first_idx = 0;
    bit finished = 1'b0;
    logic [NN-1:0] mask = '0;
    for (int i = NN - 1; i >= 0; i--) if (t.exp_mask[i]) first_idx = i;
    i_tick = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (cyc < 300 && !finished) begin
      if (cyc == 1) check({t.name, ".busy_rise"}, o_busy, 1);
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (o_overrun) ovr++;
      if (done_cnt > 0 && !o_busy) finished = 1'b1;
      i_tick = (t.extra_tick && cyc == 2);
      bus.i_syn_valid = 1'b0;
      bus.i_evt_ready = 1'b0;
      if (bus.o_req_valid) begin
        if (bus.o_req_idx == 3'd0 && delay_cnt < t.syn_delay) begin
          check({t.name, ".req_idx_hold"}, bus.o_req_idx, 0);
          delay_cnt++;
        end else begin
          bus.i_syn_valid   = 1'b1;
          bus.i_sum_excit   = t.ex[bus.o_req_idx];
          bus.i_sum_inhibit = t.inh[bus.o_req_idx];
        end
      end
      if (bus.o_evt_valid) begin
        if (stall_cnt < t.stall) begin
          check({t.name, ".stall_evt_idx"}, bus.o_evt_idx, first_idx);
          check({t.name, ".stall_no_req"}, bus.o_req_valid, 0);
          stall_cnt++;
        end else begin
          bus.i_evt_ready = 1'b1;
          evt_cnt++;
          mask[bus.o_evt_idx] = 1'b1;
        end
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    i_tick = 1'b0;
    bus.i_syn_valid = 1'b0;
    bus.i_evt_ready = 1'b0;
    check({t.name, ".finished"}, finished, 1);
    check({t.name, ".evt_count"}, evt_cnt, t.exp_cnt);
    check({t.name, ".evt_mask"}, mask, t.exp_mask);
    check({t.name, ".done_count"}, done_cnt, 1);
    check({t.name, ".done_cycle"}, done_cyc, t.exp_done_cyc);
    check({t.name, ".overrun"}, ovr, t.exp_ovr);
    check({t.name, ".v"}, snap_v(), t.exp_v);
    check({t.name, ".r"}, snap_r(), t.exp_r);
  endtask

  initial begin
    bit found;
    bus.i_syn_valid = 1'b0;
    bus.i_sum_excit = '0;
    bus.i_sum_inhibit = '0;
    bus.i_evt_ready = 1'b0;

    vecs[0] = blank("single_fire");
    vecs[0].ex[0] = 14'h1400;
    vecs[0].exp_mask = 8'b0000_0001;
    vecs[0].exp_cnt = 1;
    vecs[0].exp_done_cyc = 18;
    vecs[0].exp_r[0] = 4'd2;

    vecs[1] = blank("clamp_preload");
    vecs[1].ex[0] = 14'h3FFF;
    vecs[1].ex[1] = 14'h0100;
    vecs[1].inh[1] = 14'h0200;
    vecs[1].ex[2] = 14'h0800;
    vecs[1].ex[6] = 14'h1000;
    vecs[1].exp_v[2] = 14'h0800;
    vecs[1].exp_v[6] = 14'h1000;
    vecs[1].exp_r[0] = 4'd1;

    vecs[2] = blank("decay_sat");
    vecs[2].ex[0] = 14'h3FFF;
    vecs[2].ex[2] = 14'h0100;
    vecs[2].ex[6] = 14'h3FFF;
    vecs[2].exp_mask = 8'b0100_0000;
    vecs[2].exp_cnt = 1;
    vecs[2].exp_done_cyc = 18;
    vecs[2].exp_v[2] = 14'h0800;
    vecs[2].exp_r[6] = 4'd2;

    vecs[3] = blank("refire");
    vecs[3].ex[0] = 14'h3FFF;
    vecs[3].exp_mask = 8'b0000_0001;
    vecs[3].exp_cnt = 1;
    vecs[3].exp_done_cyc = 18;
    vecs[3].exp_v[2] = 14'h0700;
    vecs[3].exp_r[0] = 4'd2;
    vecs[3].exp_r[6] = 4'd1;

    vecs[4] = blank("backpressure");
    vecs[4].ex[3] = 14'h1400;
    vecs[4].ex[5] = 14'h2000;
    vecs[4].stall = 5;
    vecs[4].exp_mask = 8'b0010_1000;
    vecs[4].exp_cnt = 2;
    vecs[4].exp_done_cyc = 24;
    vecs[4].exp_v[2] = 14'h0620;
    vecs[4].exp_r[0] = 4'd1;
    vecs[4].exp_r[3] = 4'd2;
    vecs[4].exp_r[5] = 4'd2;

    vecs[5] = blank("overrun_stall");
    vecs[5].syn_delay = 4;
    vecs[5].extra_tick = 1'b1;
    vecs[5].exp_done_cyc = 21;
    vecs[5].exp_ovr = 1;
    vecs[5].exp_v[2] = 14'h055C;
    vecs[5].exp_r[3] = 4'd1;
    vecs[5].exp_r[5] = 4'd1;

    vecs[6] = blank("post_reset");

    repeat (2) @(negedge clk);
    check("reset.outputs", {bus.o_req_valid, bus.o_req_idx, bus.o_evt_valid, bus.o_evt_idx,
                            o_busy, o_done, o_overrun}, 0);
    check("reset.v", snap_v(), 0);
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Reset mid-sweep once neuron 4 is being requested.
    found = 1'b0;
    i_tick = 1'b1;
    @(negedge clk);
    i_tick = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      bus.i_syn_valid = 1'b0;
      if (bus.o_req_valid && bus.o_req_idx == 3'd4) begin
        found = 1'b1;
      end else begin
        if (bus.o_req_valid) begin
          bus.i_syn_valid = 1'b1;
          bus.i_sum_excit = 14'h0500;
          bus.i_sum_inhibit = '0;
        end
        @(negedge clk);
      end
    end
    check("midreset.reached_idx4", found, 1);
    check("midreset.v0_written", dut.v_q[0], 14'h0500);
    #2 reset = 1'b0;
    #1;
    check("midreset.outputs", {bus.o_req_valid, bus.o_req_idx, bus.o_evt_valid, bus.o_evt_idx,
                               o_busy, o_done, o_overrun}, 0);
    check("midreset.v", snap_v(), 0);
    check("midreset.r", snap_r(), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_vec(vecs[6]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
